// File: rtl/pit_pkg.sv
// ---------------------------------------------------------------------------
// pit_pkg
// Shared definitions for the PIT bus controller slice.
//   - I/O port offsets of the 8254-style timer (counters 0..2, control word)
//   - control-word / read-back command bit positions
//   - half-period rate constant for the nominal 1.193182 MHz PIT clock
//   - strobe bundle type and the one-hot counter-select helper
// ---------------------------------------------------------------------------
package pit_pkg;

    // I/O port offsets
    localparam logic [1:0] PIT_CH0  = 2'd0;
    localparam logic [1:0] PIT_CH1  = 2'd1;
    localparam logic [1:0] PIT_CH2  = 2'd2;
    localparam logic [1:0] PIT_CTRL = 2'd3;

    // Control word: bits[7:6] select the counter, bits[5:4] select access mode
    localparam int unsigned CW_SEL_LSB   = 32'd6;
    localparam int unsigned CW_RW_LSB    = 32'd4;
    localparam logic [1:0]  CW_SEL_RB    = 2'd3;
    localparam logic [1:0]  CW_RW_LATCH  = 2'd0;

    // Read-back command: bit[N+1] selects counter N, bit5/bit4 are active-low
    // "latch count" / "latch status" enables
    localparam int unsigned RB_SEL_LSB   = 32'd1;
    localparam int unsigned RB_NO_STATUS = 32'd4;
    localparam int unsigned RB_NO_COUNT  = 32'd5;

    // Twice the nominal PIT frequency: one accumulator overflow per half period
    localparam int unsigned PIT_HZ2         = 32'd2386364;
    // Smallest clk rate that still gives every pit_clock phase at least 2 clk
    localparam int unsigned PIT_MIN_CLK_HZ  = 32'd4772728;

    // One bundle of all per-counter strobes
    typedef struct packed {
        logic [2:0] set_control_mode;
        logic [2:0] latch_count;
        logic [2:0] latch_status;
        logic [2:0] write;
        logic [2:0] read;
    } pit_strobe_t;

    // Counter index -> one-hot counter select (index 3 selects nothing)
    function automatic logic [2:0] pit_onehot3(input logic [1:0] idx);
        logic [2:0] sel;
        case (idx)
            2'd0:    sel = 3'b001;
            2'd1:    sel = 3'b010;
            2'd2:    sel = 3'b100;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/pit_clk_gen.sv
// ---------------------------------------------------------------------------
// pit_clk_gen
// Fractional clock generator producing the nominal 1.193182 MHz PIT clock
// from clk. A 32-bit phase accumulator advances by PIT_HZ2 each clk; each
// time it reaches CLK_HZ the remainder is kept and pit_clock toggles, so the
// long-term rate is exact and the edge jitter is at most one clk.
// Ports:
//   clk       in   system clock (CLK_HZ Hz)
//   rst       in   asynchronous active-high reset
//   pit_clock out  generated PIT clock (registered)
// ---------------------------------------------------------------------------
module pit_clk_gen
    import pit_pkg::*;
#(
    parameter int unsigned CLK_HZ = 32'd30000000
) (
    input  logic clk,
    input  logic rst,
    output logic pit_clock
);

    // Slower clocks would allow single-clk phases on pit_clock
    if (CLK_HZ < PIT_MIN_CLK_HZ) begin : g_clk_hz_too_low
        $error("pit_clk_gen: CLK_HZ must be >= 4772728");
    end

    logic [31:0] acc_r;
    logic [31:0] acc_next_s;
    logic [32:0] sum_s;
    logic        wrap_s;
    logic        pit_clock_r;

    // Next accumulator value and overflow detection (33-bit sum avoids wrap)
    always_comb begin
        sum_s      = {1'b0, acc_r} + 33'(PIT_HZ2);
        wrap_s     = 1'b0;
        acc_next_s = sum_s[31:0];
        if (sum_s >= 33'(CLK_HZ)) begin
            wrap_s     = 1'b1;
            acc_next_s = 32'(sum_s - 33'(CLK_HZ));
        end else begin
            wrap_s     = 1'b0;
            acc_next_s = sum_s[31:0];
        end
    end

    // Accumulator and output toggle register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r       <= 32'd0;
            pit_clock_r <= 1'b0;
        end else begin
            acc_r       <= acc_next_s;
            pit_clock_r <= pit_clock_r ^ wrap_s;
        end
    end

    assign pit_clock = pit_clock_r;

endmodule

// File: rtl/pit_bus_ctrl.sv
// ---------------------------------------------------------------------------
// pit_bus_ctrl
// Host I/O front end for an 8254-style PIT: decodes byte-wide port accesses
// into one-cycle per-counter strobes, returns counter read data, generates
// the PIT input clock and turns rising edges of counter 0 output into IRQ0
// pulses. All strobes and read data are registered (1 clk after the access).
// Optional feature: define PIT_READBACK_EN to decode control words with
// bits[7:6] == 3 as read-back commands; otherwise such words are ignored.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   io_address/read/write/...   host port access (offset 0..3, 1-cycle strobes)
//   io_readdata                 registered read data (8'hFF for offset 3)
//   data_in                     last write data, shared by all counters
//   set_control_mode, latch_count, latch_status, write, read
//                               one-hot per-counter strobes
//   data_out0..2                per-counter read data
//   pit_clock                   generated ~1.193182 MHz counter clock
//   out0, irq0_pulse            counter 0 output and its rising-edge pulse
// ---------------------------------------------------------------------------
module pit_bus_ctrl
    import pit_pkg::*;
#(
    parameter int unsigned CLK_HZ = 32'd30000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] io_address,
    input  logic       io_read,
    input  logic       io_write,
    input  logic [7:0] io_writedata,
    output logic [7:0] io_readdata,
    output logic [7:0] data_in,
    output logic [2:0] set_control_mode,
    output logic [2:0] latch_count,
    output logic [2:0] latch_status,
    output logic [2:0] write,
    output logic [2:0] read,
    input  logic [7:0] data_out0,
    input  logic [7:0] data_out1,
    input  logic [7:0] data_out2,
    output logic       pit_clock,
    input  logic       out0,
    output logic       irq0_pulse
);

    pit_strobe_t strb_s;
    pit_strobe_t strb_r;
    logic [7:0]  data_in_next_s;
    logic [7:0]  data_in_r;
    logic [7:0]  rdata_next_s;
    logic [7:0]  rdata_r;
    logic        out0_last_r;
    logic        irq0_pulse_r;
    logic [1:0]  cw_sel_s;
    logic [1:0]  cw_rw_s;

    assign cw_sel_s = io_writedata[CW_SEL_LSB +: 2];
    assign cw_rw_s  = io_writedata[CW_RW_LSB +: 2];

    // Access decode: next strobes, next write data and next read data
    always_comb begin
        strb_s         = '0;
        data_in_next_s = data_in_r;
        rdata_next_s   = rdata_r;

        if (io_write) begin
            data_in_next_s = io_writedata;
            if (io_address != PIT_CTRL) begin
                strb_s.write = pit_onehot3(io_address);
            end else if (cw_sel_s != CW_SEL_RB) begin
                if (cw_rw_s != CW_RW_LATCH) begin
                    strb_s.set_control_mode = pit_onehot3(cw_sel_s);
                end else begin
                    strb_s.latch_count = pit_onehot3(cw_sel_s);
                end
            end else begin
`ifdef PIT_READBACK_EN
                // Read-back: both latch types may fire together for several counters
                for (int n = 0; n < 3; n++) begin
                    strb_s.latch_count[n]  = io_writedata[RB_SEL_LSB + n] & ~io_writedata[RB_NO_COUNT];
                    strb_s.latch_status[n] = io_writedata[RB_SEL_LSB + n] & ~io_writedata[RB_NO_STATUS];
                end
`else
                strb_s.latch_count  = 3'b000;
                strb_s.latch_status = 3'b000;
`endif
            end
        end else begin
            data_in_next_s = data_in_r;
        end

        // Read data is sampled now, before the counter sees its read pulse;
        // a colliding write wins and the read returns all ones.
        if (io_read) begin
            if (io_write) begin
                rdata_next_s = 8'hFF;
            end else begin
                case (io_address)
                    PIT_CH0:  rdata_next_s = data_out0;
                    PIT_CH1:  rdata_next_s = data_out1;
                    PIT_CH2:  rdata_next_s = data_out2;
                    default:  rdata_next_s = 8'hFF;
                endcase
                strb_s.read = pit_onehot3(io_address);
            end
        end else begin
            rdata_next_s = rdata_r;
        end
    end

    // Output registers for strobes, write data and read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strb_r    <= '0;
            data_in_r <= 8'h00;
            rdata_r   <= 8'hFF;
        end else begin
            strb_r    <= strb_s;
            data_in_r <= data_in_next_s;
            rdata_r   <= rdata_next_s;
        end
    end

    // IRQ0 edge detector; out0_last resets high so a high out0 at reset
    // release does not produce a spurious interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out0_last_r  <= 1'b1;
            irq0_pulse_r <= 1'b0;
        end else begin
            out0_last_r  <= out0;
            irq0_pulse_r <= out0 & ~out0_last_r;
        end
    end

    pit_clk_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .pit_clock(pit_clock)
    );

    assign set_control_mode = strb_r.set_control_mode;
    assign latch_count      = strb_r.latch_count;
    assign latch_status     = strb_r.latch_status;
    assign write            = strb_r.write;
    assign read             = strb_r.read;
    assign data_in          = data_in_r;
    assign io_readdata      = rdata_r;
    assign irq0_pulse       = irq0_pulse_r;

endmodule

// File: tb/tb_pit_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pit_bus_ctrl
// Scoreboard bench for pit_bus_ctrl: stimulus pushes expected strobe bundles
// and expected read data into queues; a monitor popping at each negedge
// compares whenever the DUT presents a strobe or a read completes.
// ---------------------------------------------------------------------------
module tb_pit_bus_ctrl;

    typedef struct packed {
        logic [2:0] scm;
        logic [2:0] lc;
        logic [2:0] ls;
        logic [2:0] wr;
        logic [2:0] rd;
        logic [7:0] din;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] io_address;
    logic       io_read;
    logic       io_write;
    logic [7:0] io_writedata;
    logic [7:0] io_readdata;
    logic [7:0] data_in;
    logic [2:0] set_control_mode;
    logic [2:0] latch_count;
    logic [2:0] latch_status;
    logic [2:0] write;
    logic [2:0] read;
    logic [7:0] data_out0;
    logic [7:0] data_out1;
    logic [7:0] data_out2;
    logic       pit_clock;
    logic       out0;
    logic       irq0_pulse;

    exp_t       exp_q[$];
    logic [7:0] rd_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       rd_prev = 1'b0;
    int         irq_cnt = 0;
    logic       clk_mon_en = 1'b0;
    int         toggles = 0;
    int         phase_len = 0;
    logic       seen_toggle = 1'b0;
    logic       pclk_prev = 1'b0;
    logic [7:0] last_din = 8'h00;

    pit_bus_ctrl #(.CLK_HZ(32'd30000000)) dut (
        .clk             (clk),
        .rst             (rst),
        .io_address      (io_address),
        .io_read         (io_read),
        .io_write        (io_write),
        .io_writedata    (io_writedata),
        .io_readdata     (io_readdata),
        .data_in         (data_in),
        .set_control_mode(set_control_mode),
        .latch_count     (latch_count),
        .latch_status    (latch_status),
        .write           (write),
        .read            (read),
        .data_out0       (data_out0),
        .data_out1       (data_out1),
        .data_out2       (data_out2),
        .pit_clock       (pit_clock),
        .out0            (out0),
        .irq0_pulse      (irq0_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] scm, input logic [2:0] lc, input logic [2:0] ls,
                                input logic [2:0] wr, input logic [2:0] rd, input logic [7:0] din);
        exp_t e;
        e = {scm, lc, ls, wr, rd, din};
        return e;
    endfunction

    // Monitor: runs forever at negedge, popping expectations when outputs show
    task automatic monitor_loop();
        exp_t       e;
        logic [7:0] er;
        forever begin
            @(negedge clk);
            if (rd_prev) begin
                if (rd_q.size() == 0) begin
                    check("readdata_unexpected", 32'(io_readdata), 32'hDEAD);
                end else begin
                    er = rd_q.pop_front();
                    check("io_readdata", 32'(io_readdata), 32'(er));
                end
            end
            rd_prev = io_read;
            if ({set_control_mode, latch_count, latch_status, write, read} != 15'd0) begin
                if (exp_q.size() == 0) begin
                    check("strobe_unexpected",
                          32'({set_control_mode, latch_count, latch_status, write, read}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("set_control_mode", 32'(set_control_mode), 32'(e.scm));
                    check("latch_count", 32'(latch_count), 32'(e.lc));
                    check("latch_status", 32'(latch_status), 32'(e.ls));
                    check("write", 32'(write), 32'(e.wr));
                    check("read", 32'(read), 32'(e.rd));
                    check("data_in", 32'(data_in), 32'(e.din));
                end
            end
            if (irq0_pulse === 1'b1) irq_cnt++;
            if (clk_mon_en) begin
                phase_len++;
                if (pit_clock !== pclk_prev) begin
                    toggles++;
                    // ideal phase is 12.57 clk; with <=1 clk jitter it is 12 or 13
                    if (seen_toggle) check_range("pit_phase_len", phase_len, 12, 13);
                    seen_toggle = 1'b1;
                    phase_len   = 0;
                end
            end
            pclk_prev = pit_clock;
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        io_address = a; io_writedata = d; io_write = 1'b1;
        last_din = d;
        @(posedge clk); #1;
        io_write = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] a);
        @(posedge clk); #1;
        io_address = a; io_read = 1'b1;
        @(posedge clk); #1;
        io_read = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        io_address = 2'd0; io_read = 1'b0; io_write = 1'b0; io_writedata = 8'h00;
        data_out0 = 8'h3C; data_out1 = 8'h5A; data_out2 = 8'hC3;
        out0 = 1'b0;
        fork
            monitor_loop();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobes", 32'({set_control_mode, latch_count, latch_status, write, read}), 32'd0);
        check("rst_data_in", 32'(data_in), 32'h00);
        check("rst_readdata", 32'(io_readdata), 32'hFF);
        check("rst_pit_clock", 32'(pit_clock), 32'd0);
        check("rst_irq0", 32'(irq0_pulse), 32'd0);

        // Clock generator: 30000 clk -> floor(30000*2386364/30e6) = 2386 toggles
        rst = 1'b0;
        toggles = 0; phase_len = 0; seen_toggle = 1'b0;
        clk_mon_en = 1'b1;
        repeat (30000) @(posedge clk);
        #1;
        clk_mon_en = 1'b0;
        check_range("pit_toggles", toggles, 2385, 2387);

        // Control words
        exp_q.push_back(mk(3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 8'h34));
        do_write(2'd3, 8'h34);
        exp_q.push_back(mk(3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 8'h80));
        do_write(2'd3, 8'h80);
        exp_q.push_back(mk(3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 8'h7A));
        do_write(2'd3, 8'h7A);
        // Counter data writes
        exp_q.push_back(mk(3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 8'hA5));
        do_write(2'd0, 8'hA5);
        exp_q.push_back(mk(3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 8'h0F));
        do_write(2'd2, 8'h0F);
        // Read-back command (or nothing without the feature)
`ifdef PIT_READBACK_EN
        exp_q.push_back(mk(3'b000, 3'b011, 3'b011, 3'b000, 3'b000, 8'hC6));
`endif
        do_write(2'd3, 8'hC6);
        check("data_in_after_C6", 32'(data_in), 32'hC6);

        // Reads
        rd_q.push_back(8'h5A);
        exp_q.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b010, last_din));
        do_read(2'd1);
        rd_q.push_back(8'hFF);
        do_read(2'd3);
        rd_q.push_back(8'h3C);
        exp_q.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b001, last_din));
        do_read(2'd0);
        rd_q.push_back(8'hC3);
        exp_q.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b100, last_din));
        do_read(2'd2);

        // Simultaneous read and write at offset 1: write wins, read gives FF
        rd_q.push_back(8'hFF);
        exp_q.push_back(mk(3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 8'h11));
        @(posedge clk); #1;
        io_address = 2'd1; io_writedata = 8'h11; io_write = 1'b1; io_read = 1'b1;
        @(posedge clk); #1;
        io_write = 1'b0; io_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // IRQ0: out0 0->1->0->1 gives exactly two single-cycle pulses
        irq_cnt = 0;
        out0 = 1'b1; repeat (4) @(posedge clk); #1;
        out0 = 1'b0; repeat (4) @(posedge clk); #1;
        out0 = 1'b1; repeat (4) @(posedge clk); #1;
        check("irq0_pulse_count", 32'(irq_cnt), 32'd2);

        // Reset mid-pulse with a write strobe in flight: both vanish at once
        out0 = 1'b0; repeat (4) @(posedge clk); #1;
        out0 = 1'b1; io_address = 2'd0; io_writedata = 8'h55; io_write = 1'b1;
        @(posedge clk); #1;
        io_write = 1'b0;
        check("irq0_before_rst", 32'(irq0_pulse), 32'd1);
        check("write_before_rst", 32'(write), 32'b001);
        rst = 1'b1;
        #1;
        check("irq0_in_rst", 32'(irq0_pulse), 32'd0);
        check("write_in_rst", 32'(write), 32'd0);
        check("data_in_in_rst", 32'(data_in), 32'h00);
        check("readdata_in_rst", 32'(io_readdata), 32'hFF);
        repeat (3) @(posedge clk); #1;
        // out0 stays high through reset release: no interrupt expected
        irq_cnt = 0;
        rst = 1'b0;
        repeat (6) @(posedge clk); #1;
        check("irq0_after_rst", 32'(irq_cnt), 32'd0);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
